tft_colorbar_top: RTL and testbench
===================================

Name: tft_colorbar_top

Overview:
- Self-contained test-pattern source for a 480x272 RGB565 TFT panel.
- Derives a pixel clock from the 50 MHz system clock and generates hsync, vsync and data-enable timing.
- Drives ten equal vertical colour bars plus a constant-on backlight.
- Top-level block, pins go straight to the panel connector.

Parameters:
- CLK_DIV, 6, sys_clk cycles per pixel (50 MHz / 6 ≈ 8.33 MHz); must be ≥ 2.
- H_SYNC, 41, hsync pulse width in pixels.
- H_BACK, 2, horizontal back porch in pixels.
- H_VALID, 480, active pixels per line.
- H_FRONT, 2, horizontal front porch; H_TOTAL = 525.
- V_SYNC, 10, vsync pulse width in lines.
- V_BACK, 2, vertical back porch in lines.
- V_VALID, 272, active lines per frame.
- V_FRONT, 2, vertical front porch; V_TOTAL = 286.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- tft_rgb  out  16  pixel data, RGB565 (R[15:11] G[10:5] B[4:0]).
- hsync  out  1  line sync, active-high pulse.
- vsync  out  1  frame sync, active-high pulse.
- tft_de  out  1  data enable, high during active area.
- tft_clk  out  1  pixel clock to panel.
- tft_bl  out  1  backlight enable.

Behaviour:
- All state is in the sys_clk domain; no internal clock is used as a clock.
- Reset values: all registers and outputs 0 (tft_rgb = 16'h0000, hsync/vsync/tft_de/tft_clk/tft_bl = 0).
- Divider counter div_cnt runs 0..CLK_DIV-1 and wraps.
- pix_en is high when div_cnt == CLK_DIV-1.
- tft_clk is a register: high while div_cnt < CLK_DIV/2 (integer division), else low. With the default this is 3 cycles high, 3 low.
- Output registers update on the cycle after pix_en, coincident with the tft_clk rising edge. The panel samples on the tft_clk falling edge, mid-pixel.
- Horizontal counter h_cnt (0..H_TOTAL-1) advances on pix_en and wraps.
- Vertical counter v_cnt (0..V_TOTAL-1) advances on pix_en when h_cnt == H_TOTAL-1, wrapping at V_TOTAL-1.
- On each pix_en, the output registers load a decode of the current h_cnt/v_cnt, so outputs lag the counters by exactly one pixel:
  - hsync = (h_cnt < H_SYNC)
  - vsync = (v_cnt < V_SYNC)
  - tft_de = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID)
- Pixel coordinate: x = h_cnt - (H_SYNC+H_BACK). Bar index = x / 48, giving 10 bars of 48 pixels.
- Bar colours, in order 0..9:
  - 0 WHITE FFFF
  - 1 BLACK 0000
  - 2 RED F800
  - 3 ORANGE FC00
  - 4 YELLOW FFE0
  - 5 GREEN 07E0
  - 6 CYAN 07FF
  - 7 BLUE 001F
  - 8 PURPLE F81F
  - 9 GRAY D69A
- Colour is independent of y.
- tft_rgb = 16'h0000 whenever the decoded tft_de is 0.
- tft_bl: register set to 1 on the first sys_clk edge after reset deassert and held at 1 until the next reset.
- Reset asserted mid-frame:
  - all outputs go to 0 immediately (asynchronous);
  - counters restart at 0;
  - the first pix_en after release begins frame 0, line 0, pixel 0.
- Frame period = 525 × 286 × CLK_DIV sys_clk cycles = 900,900 cycles = 18.018 ms at default settings.

Decomposition:
- Package tft_pkg holds:
  - timing constants H_*/V_*, H_TOTAL, V_TOTAL;
  - BAR_WIDTH = 48;
  - the ten RGB565 colour constants.
- One natural sub-module, tft_timing_gen, owns:
  - the divider, pix_en and tft_clk;
  - h_cnt/v_cnt;
  - the sync/de decode.
  It exports pix_en, x, and a de flag.
- Top-level holds the colour-bar lookup and the output registers.

Test Plan:
- Reset held 20 ns, then released:
  - all outputs are 0 during reset;
  - tft_bl = 1 one sys_clk later;
  - tft_clk period is 120 ns, 60 ns high / 60 ns low.
- hsync timing: high for 41 pixels (4920 ns), period 525 pixels (63 µs).
- vsync timing: high for 10 lines (630 µs), period 286 lines (18.018 ms).
- tft_de timing:
  - first rises on line 12, pixel 43;
  - high for 480 consecutive pixels per line;
  - exactly 272 active lines per frame;
  - tft_rgb is 0000 whenever tft_de = 0.
- Colour bars, sampled on tft_clk falling edges in an active line:
  - pixels 0–47 = FFFF;
  - pixel 48 = 0000;
  - pixel 96 = F800;
  - pixel 335 = 07FF;
  - pixel 336 = 001F;
  - pixels 432–479 = D69A;
  - the same pattern repeats on every active line.
- Mid-frame reset pulse (40 ns) at line ~100:
  - outputs drop to 0 asynchronously;
  - after release, hsync/vsync restart aligned to pixel 0 / line 0;
  - the next full frame period is again 18.018 ms.

Source files
------------

// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - timing constants and colour-bar palette for the 480x272 RGB565 test pattern
package tft_pkg;

    localparam int CLK_DIV = 6;

    localparam int H_SYNC  = 41;
    localparam int H_BACK  = 2;
    localparam int H_VALID = 480;
    localparam int H_FRONT = 2;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

    localparam int V_SYNC  = 10;
    localparam int V_BACK  = 2;
    localparam int V_VALID = 272;
    localparam int V_FRONT = 2;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam int BAR_WIDTH = 48;

    localparam logic [15:0] COLOR_WHITE  = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK  = 16'h0000;
    localparam logic [15:0] COLOR_RED    = 16'hF800;
    localparam logic [15:0] COLOR_ORANGE = 16'hFC00;
    localparam logic [15:0] COLOR_YELLOW = 16'hFFE0;
    localparam logic [15:0] COLOR_GREEN  = 16'h07E0;
    localparam logic [15:0] COLOR_CYAN   = 16'h07FF;
    localparam logic [15:0] COLOR_BLUE   = 16'h001F;
    localparam logic [15:0] COLOR_PURPLE = 16'hF81F;
    localparam logic [15:0] COLOR_GRAY   = 16'hD69A;

    // Bars beyond the tenth (only possible with a wider H_VALID) read as black.
    function automatic logic [15:0] bar_color(input int unsigned idx);
        logic [15:0] c;
        case (idx)
            0:       c = COLOR_WHITE;
            1:       c = COLOR_BLACK;
            2:       c = COLOR_RED;
            3:       c = COLOR_ORANGE;
            4:       c = COLOR_YELLOW;
            5:       c = COLOR_GREEN;
            6:       c = COLOR_CYAN;
            7:       c = COLOR_BLUE;
            8:       c = COLOR_PURPLE;
            9:       c = COLOR_GRAY;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tft_if.sv
// rtl/tft_if.sv - panel-side RGB565 TFT signal bundle
interface tft_if;

    logic [15:0] tft_rgb;
    logic        hsync;
    logic        vsync;
    logic        tft_de;
    logic        tft_clk;
    logic        tft_bl;

    modport master (
        output tft_rgb,
        output hsync,
        output vsync,
        output tft_de,
        output tft_clk,
        output tft_bl
    );

    modport slave (
        input tft_rgb,
        input hsync,
        input vsync,
        input tft_de,
        input tft_clk,
        input tft_bl
    );

endinterface

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - pixel-rate enable, panel clock, raster counters and sync/de decode
module tft_timing_gen #(
    parameter int CLK_DIV = tft_pkg::CLK_DIV,
    parameter int H_SYNC  = tft_pkg::H_SYNC,
    parameter int H_BACK  = tft_pkg::H_BACK,
    parameter int H_VALID = tft_pkg::H_VALID,
    parameter int H_FRONT = tft_pkg::H_FRONT,
    parameter int V_SYNC  = tft_pkg::V_SYNC,
    parameter int V_BACK  = tft_pkg::V_BACK,
    parameter int V_VALID = tft_pkg::V_VALID,
    parameter int V_FRONT = tft_pkg::V_FRONT,
    parameter int HW      = $clog2(H_SYNC + H_BACK + H_VALID + H_FRONT + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    output logic          pix_en,
    output logic          tft_clk,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [HW-1:0] x
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BACK + H_VALID);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BACK + V_VALID);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end

    assign pix_en = (div_cnt == DIV_LAST);

    // tft_clk follows the value div_cnt is about to take, so it rises on the
    // same edge that loads the output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt <= '0;
            tft_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            tft_clk <= (div_nxt < DIV_HALF);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        hs = (h_cnt < HW'(H_SYNC));
        vs = (v_cnt < VW'(V_SYNC));
        de = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
             (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        x  = h_cnt - H_ACT_BEG;
    end

endmodule

// File: rtl/tft_colorbar_top.sv
// rtl/tft_colorbar_top.sv - ten-bar RGB565 test pattern source driving the TFT panel pins
module tft_colorbar_top #(
    parameter int CLK_DIV = tft_pkg::CLK_DIV,
    parameter int H_SYNC  = tft_pkg::H_SYNC,
    parameter int H_BACK  = tft_pkg::H_BACK,
    parameter int H_VALID = tft_pkg::H_VALID,
    parameter int H_FRONT = tft_pkg::H_FRONT,
    parameter int V_SYNC  = tft_pkg::V_SYNC,
    parameter int V_BACK  = tft_pkg::V_BACK,
    parameter int V_VALID = tft_pkg::V_VALID,
    parameter int V_FRONT = tft_pkg::V_FRONT
) (
    input  logic  sys_clk,
    input  logic  sys_rst,
    tft_if.master panel
);

    import tft_pkg::*;

    localparam int HW = $clog2(H_SYNC + H_BACK + H_VALID + H_FRONT + 1);

    logic          pix_en;
    logic          clk_q;
    logic          hs;
    logic          vs;
    logic          de;
    logic [HW-1:0] x;
    logic [HW-1:0] bar_idx;
    logic [15:0]   color;

    logic [15:0]   rgb_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic          bl_q;

    tft_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_VALID (H_VALID),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_VALID (V_VALID),
        .V_FRONT (V_FRONT),
        .HW      (HW)
    ) u_timing (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pix_en  (pix_en),
        .tft_clk (clk_q),
        .hs      (hs),
        .vs      (vs),
        .de      (de),
        .x       (x)
    );

    always_comb begin
        bar_idx = x / HW'(BAR_WIDTH);
        color   = de ? bar_color(int'(bar_idx)) : 16'h0000;
    end

    // Outputs lag the counters by one pixel; the backlight latches on after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rgb_q   <= 16'h0000;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            bl_q <= 1'b1;
            if (pix_en) begin
                rgb_q   <= color;
                hsync_q <= hs;
                vsync_q <= vs;
                de_q    <= de;
            end
        end
    end

    assign panel.tft_rgb = rgb_q;
    assign panel.hsync   = hsync_q;
    assign panel.vsync   = vsync_q;
    assign panel.tft_de  = de_q;
    assign panel.tft_clk = clk_q;
    assign panel.tft_bl  = bl_q;

endmodule

// File: tb/tb_tft_colorbar_top.sv
// tb/tb_tft_colorbar_top.sv - self-checking bench for tft_colorbar_top with a closed-form raster model
module tb_tft_colorbar_top;

    localparam int D     = 3;
    localparam int HS    = 41;
    localparam int HB    = 2;
    localparam int HV    = 480;
    localparam int HF    = 2;
    localparam int VS    = 3;
    localparam int VB    = 1;
    localparam int VV    = 3;
    localparam int VF    = 1;
    localparam int HT    = HS + HB + HV + HF;
    localparam int VT    = VS + VB + VV + VF;
    localparam int FRAME = HT * VT;
    localparam int PER   = 20;

    typedef struct packed {
        logic        bl;
        logic        clk;
        logic        de;
        logic        vs;
        logic        hs;
        logic [15:0] rgb;
    } outs_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    time  rel_t = 0;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] bar_tab [10] = '{16'hFFFF, 16'h0000, 16'hF800, 16'hFC00, 16'hFFE0,
                                  16'h07E0, 16'h07FF, 16'h001F, 16'hF81F, 16'hD69A};

    tft_if tft ();

    tft_colorbar_top #(
        .CLK_DIV (D),
        .H_SYNC  (HS),
        .H_BACK  (HB),
        .H_VALID (HV),
        .H_FRONT (HF),
        .V_SYNC  (VS),
        .V_BACK  (VB),
        .V_VALID (VV),
        .V_FRONT (VF)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .panel   (tft)
    );

    always #(PER/2) sys_clk = ~sys_clk;

    // Rising sys_clk edges since reset release (valid when called on a falling edge).
    function automatic longint n_now();
        return longint'(($time - rel_t) / PER);
    endfunction

    // Expected pins after n edges: pixel k-1 of the raster is shown after edge k*D.
    function automatic outs_t model(input longint n);
        outs_t  o;
        longint k;
        longint p;
        int     h;
        int     v;
        o = '0;
        if (n < 1) return o;
        o.bl = 1'b1;
        o.clk = ((n % D) < (D / 2));
        k = n / D;
        if (k == 0) return o;
        p = (k - 1) % FRAME;
        h = int'(p % HT);
        v = int'(p / HT);
        o.hs = (h < HS);
        o.vs = (v < VS);
        o.de = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
        if (o.de) o.rgb = bar_tab[(h - HS - HB) / 48];
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.bl  = tft.tft_bl;
        o.clk = tft.tft_clk;
        o.de  = tft.tft_de;
        o.vs  = tft.vsync;
        o.hs  = tft.hsync;
        o.rgb = tft.tft_rgb;
        return o;
    endfunction

    task automatic test_reset();
        outs_t obs;
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        obs = observe();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_hold got %h exp %h", obs, outs_t'('0));
        end
        sys_rst = 1'b0;
        rel_t = $time;
        #1;
        obs = observe();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_release got %h exp %h", obs, outs_t'('0));
        end
        @(negedge sys_clk);
        obs = observe();
        tests++;
        if (obs.bl !== 1'b1 || obs !== model(1)) begin
            fails++;
            $display("FAIL backlight_on got %h exp %h", obs, model(1));
        end
    endtask

    task automatic test_stream(input longint ncyc, input string name);
        outs_t obs;
        outs_t exp;
        for (longint i = 0; i < ncyc; i++) begin
            @(negedge sys_clk);
            obs = observe();
            exp = model(n_now());
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s n=%0d got %h exp %h", name, n_now(), obs, exp);
            end
        end
    endtask

    // Sample on the tft_clk falling edge of each chosen pixel, as the panel does.
    task automatic check_pixels(input int f, input int line, input int xs[$],
                                input logic [15:0] cs[$], input string name);
        longint tgt;
        for (int i = 0; i < xs.size(); i++) begin
            tgt = longint'(D) * (1 + longint'(f) * FRAME + line * HT + HS + HB + xs[i]) + D / 2;
            tests++;
            if (n_now() > tgt) begin
                fails++;
                $display("FAIL %s_late x=%0d now=%0d target=%0d", name, xs[i], n_now(), tgt);
            end else begin
                while (n_now() < tgt) @(negedge sys_clk);
                if (tft.tft_rgb !== cs[i] || tft.tft_de !== 1'b1 || tft.tft_clk !== 1'b0) begin
                    fails++;
                    $display("FAIL %s x=%0d got rgb=%h de=%b clk=%b exp rgb=%h de=1 clk=0",
                             name, xs[i], tft.tft_rgb, tft.tft_de, tft.tft_clk, cs[i]);
                end
            end
        end
    endtask

    task automatic test_bars(input int f, input int line);
        int          xs[$];
        logic [15:0] cs[$];
        xs = '{0, 47, 48, 96, 335, 336, 432, 479};
        cs = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hF800, 16'h07FF, 16'h001F, 16'hD69A, 16'hD69A};
        check_pixels(f, line, xs, cs, "bar_fixed");
    endtask

    task automatic test_bars_random(input int f, input int line);
        int          xs[$];
        logic [15:0] cs[$];
        int          xv;
        for (int i = 0; i < 8; i++) begin
            xv = i * 60 + int'($urandom_range(0, 59));
            xs.push_back(xv);
            cs.push_back(bar_tab[xv / 48]);
        end
        check_pixels(f, line, xs, cs, "bar_random");
    endtask

    task automatic test_sync_timing();
        outs_t  prev;
        outs_t  cur;
        longint n;
        longint budget;
        longint vs_r0 = -1, vs_f = -1, vs_r1 = -1;
        longint hs_r0 = -1, hs_f = -1, hs_r1 = -1;
        longint de_r0 = -1, de_start = -1;
        int     de_lines = 0, bad_runs = 0, rgb_leak = 0;
        prev = observe();
        budget = 2 * longint'(FRAME) * D + 10;
        while (vs_r1 < 0 && budget > 0) begin
            @(negedge sys_clk);
            budget--;
            cur = observe();
            n = n_now();
            if (cur.vs && !prev.vs) begin
                if (vs_r0 < 0) vs_r0 = n;
                else vs_r1 = n;
            end
            if (vs_r0 >= 0 && vs_r1 < 0) begin
                if (!cur.vs && prev.vs && vs_f < 0) vs_f = n;
                if (cur.hs && !prev.hs) begin
                    if (hs_r0 < 0) hs_r0 = n;
                    else if (hs_r1 < 0) hs_r1 = n;
                end
                if (!cur.hs && prev.hs && hs_r0 >= 0 && hs_f < 0) hs_f = n;
                if (cur.de && !prev.de) begin
                    de_lines++;
                    de_start = n;
                    if (de_r0 < 0) de_r0 = n;
                end
                if (!cur.de && prev.de && de_start >= 0) begin
                    if (n - de_start != HV * D) bad_runs++;
                    de_start = -1;
                end
                if (!cur.de && cur.rgb !== 16'h0000) rgb_leak++;
            end
            prev = cur;
        end
        tests++;
        if (vs_r1 - vs_r0 != longint'(FRAME) * D) begin
            fails++;
            $display("FAIL vsync_period got %0d exp %0d", vs_r1 - vs_r0, FRAME * D);
        end
        tests++;
        if (vs_f - vs_r0 != VS * HT * D) begin
            fails++;
            $display("FAIL vsync_width got %0d exp %0d", vs_f - vs_r0, VS * HT * D);
        end
        tests++;
        if (hs_f - hs_r0 != HS * D) begin
            fails++;
            $display("FAIL hsync_width got %0d exp %0d", hs_f - hs_r0, HS * D);
        end
        tests++;
        if (hs_r1 - hs_r0 != HT * D) begin
            fails++;
            $display("FAIL hsync_period got %0d exp %0d", hs_r1 - hs_r0, HT * D);
        end
        tests++;
        if (de_r0 - vs_r0 != ((VS + VB) * HT + HS + HB) * D) begin
            fails++;
            $display("FAIL de_first got %0d exp %0d", de_r0 - vs_r0, ((VS + VB) * HT + HS + HB) * D);
        end
        tests++;
        if (de_lines != VV || bad_runs != 0) begin
            fails++;
            $display("FAIL de_lines got lines=%0d bad_runs=%0d exp lines=%0d bad_runs=0",
                     de_lines, bad_runs, VV);
        end
        tests++;
        if (rgb_leak != 0) begin
            fails++;
            $display("FAIL rgb_blank got %0d nonzero samples exp 0", rgb_leak);
        end
    endtask

    task automatic test_mid_reset();
        outs_t obs;
        int    wait_c;
        wait_c = int'($urandom_range(2 * HT * D, 5 * HT * D));
        repeat (wait_c) @(negedge sys_clk);
        obs = observe();
        tests++;
        if (obs !== model(n_now())) begin
            fails++;
            $display("FAIL pre_reset got %h exp %h", obs, model(n_now()));
        end
        #3 sys_rst = 1'b1;
        #1;
        obs = observe();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL async_reset got %h exp %h", obs, outs_t'('0));
        end
        repeat (2) @(negedge sys_clk);
        obs = observe();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_held got %h exp %h", obs, outs_t'('0));
        end
        sys_rst = 1'b0;
        rel_t = $time;
        test_stream(longint'(FRAME) * D + 100, "after_reset");
    endtask

    initial begin
        test_reset();
        test_stream(longint'(FRAME) * D + 200, "first_frame");
        test_bars(1, VS + VB);
        test_bars_random(1, VS + VB + VV - 1);
        test_sync_timing();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
